// File: rtl/ts_qos_pkg.sv
// rtl/ts_qos_pkg.sv - shared types and constants for the TS QoS channel-switch path
//
// Contents:
//   CH_W, NUM_CH  - channel index width and channel count of the TS mux
//   TS_SYNC_BYTE  - MPEG2-TS sync byte that marks each packet start
//   sw_state_t    - ts_switch_sequencer state encoding
package ts_qos_pkg;

  localparam int         CH_W         = 2;
  localparam int         NUM_CH       = 4;
  localparam logic [7:0] TS_SYNC_BYTE = 8'h47;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_GAP   = 2'd2,
    ST_DWELL = 2'd3
  } sw_state_t;

endpackage

// File: rtl/ts_switch_sequencer.sv
// rtl/ts_switch_sequencer.sv - hitless packet-aligned channel switch sequencer for the 4:1 TS mux
//
// Ports:
//   clk, rst        - system clock, synchronous active-high reset
//   sel_req         - channel requested by main_control
//   sync            - per-channel sync lock
//   pkt_start       - per-channel strobe on each packet's sync byte
//   hold_cycles     - minimum dwell after a commit, sampled on DWELL entry
//   mux_sel         - committed channel select to the datapath mux
//   mute            - output suppress while between old and new packets
//   busy            - sequence in progress (not IDLE)
//   switch_done     - pulse on commit of a new mux_sel
//   switch_forced   - pulse with switch_done when the commit came from a timeout
//   switch_abort    - pulse when a sequence ends without a commit
//   switch_count    - saturating number of commits
module ts_switch_sequencer
  import ts_qos_pkg::*;
#(
  parameter int TIMEOUT = 400,
  parameter int TMO_W   = 16,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH_W-1:0]   sel_req,
  input  logic [NUM_CH-1:0] sync,
  input  logic [NUM_CH-1:0] pkt_start,
  input  logic [19:0]       hold_cycles,
  output logic [CH_W-1:0]   mux_sel,
  output logic              mute,
  output logic              busy,
  output logic              switch_done,
  output logic              switch_forced,
  output logic              switch_abort,
  output logic [CNT_W-1:0]  switch_count
);

  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

  sw_state_t        state_q, state_d;
  logic [CH_W-1:0]  tgt_q, tgt_d;
  logic [CH_W-1:0]  cur_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [19:0]      dwell_q, dwell_d;
  logic [CNT_W-1:0] count_d;
  logic             mute_d, done_d, forced_d, abort_d;

  logic             tmo_hit;
  logic [TMO_W-1:0] tmo_inc;
  logic [CNT_W-1:0] count_inc;

  assign tmo_hit   = (tmo_q == TMO_MAX);
  assign tmo_inc   = tmo_hit ? tmo_q : tmo_q + TMO_W'(1);
  assign count_inc = (&switch_count) ? switch_count : switch_count + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    cur_d    = mux_sel;
    tmo_d    = tmo_q;
    dwell_d  = dwell_q;
    count_d  = switch_count;
    mute_d   = mute;
    done_d   = 1'b0;
    forced_d = 1'b0;
    abort_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        mute_d = 1'b0;
        // Requests toward an unlocked channel are simply not acted on.
        if ((sel_req != mux_sel) && sync[sel_req]) begin
          state_d = ST_DRAIN;
          tgt_d   = sel_req;
          tmo_d   = '0;
        end
      end

      ST_DRAIN: begin
        if (!sync[tgt_q]) begin
          state_d = ST_IDLE;
          abort_d = 1'b1;
        end else if (sel_req == mux_sel) begin
          state_d = ST_IDLE;
          abort_d = 1'b1;
        end else if (pkt_start[mux_sel]) begin
          // Old packet ended; mute until the target's next packet start,
          // even if the target strobed in this same cycle.
          state_d = ST_GAP;
          mute_d  = 1'b1;
          tmo_d   = '0;
        end else if ((sel_req != tgt_q) && sync[sel_req]) begin
          // Retarget keeps the running timeout so flapping cannot extend it.
          tgt_d = sel_req;
          tmo_d = tmo_inc;
        end else if (tmo_hit) begin
          state_d = ST_GAP;
          mute_d  = 1'b1;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_inc;
        end
      end

      ST_GAP: begin
        if (!sync[tgt_q]) begin
          state_d = ST_IDLE;
          mute_d  = 1'b0;
          abort_d = 1'b1;
        end else if (pkt_start[tgt_q] || tmo_hit) begin
          state_d  = ST_DWELL;
          cur_d    = tgt_q;
          mute_d   = 1'b0;
          done_d   = 1'b1;
          forced_d = !pkt_start[tgt_q];
          count_d  = count_inc;
          dwell_d  = hold_cycles;
        end else begin
          tmo_d = tmo_inc;
        end
      end

      ST_DWELL: begin
        if (dwell_q == 20'd0) begin
          state_d = ST_IDLE;
        end else begin
          dwell_d = dwell_q - 20'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      tgt_q         <= '0;
      tmo_q         <= '0;
      dwell_q       <= '0;
      mux_sel       <= '0;
      mute          <= 1'b0;
      busy          <= 1'b0;
      switch_done   <= 1'b0;
      switch_forced <= 1'b0;
      switch_abort  <= 1'b0;
      switch_count  <= '0;
    end else begin
      state_q       <= state_d;
      tgt_q         <= tgt_d;
      tmo_q         <= tmo_d;
      dwell_q       <= dwell_d;
      mux_sel       <= cur_d;
      mute          <= mute_d;
      busy          <= (state_d != ST_IDLE);
      switch_done   <= done_d;
      switch_forced <= forced_d;
      switch_abort  <= abort_d;
      switch_count  <= count_d;
    end
  end

endmodule

// File: doc/ts_switch_sequencer.md
# ts_switch_sequencer

Hitless channel-switch sequencer between `main_control` and the 4:1 TS output mux. `main_control` decides which channel should be on air (`sel_req`); this block applies that decision only at MPEG2-TS packet boundaries. It mutes the output during the gap between the old and new packets and enforces a minimum dwell time, so flapping error counts cannot thrash the mux.

## Interface

Parameters:
- `TIMEOUT` (default 400): maximum cycles to wait for a packet boundary in DRAIN or GAP; exceeds two 188-byte packets at 1 byte/cycle.
- `TMO_W` (default 16): width of the timeout counter.
- `CNT_W` (default 16): width of `switch_count`.

Ports:
- `clk` in, 1: single system clock.
- `rst` in, 1: synchronous, active-high reset.
- `sel_req` in, 2: requested channel from `main_control` (`mux_control`).
- `sync` in, 4: per-channel sync-lock indicator; bit i is channel i.
- `pkt_start` in, 4: one-cycle strobe on the 0x47 byte of each packet, per channel, aligned with the mux input register stage.
- `hold_cycles` in, 20: minimum dwell after a switch; from the `reset_timer`-style config field; sampled on DWELL entry.
- `mux_sel` out, 2: channel select driven to the datapath mux.
- `mute` out, 1: output null/suppress enable.
- `busy` out, 1: high in any state other than IDLE.
- `switch_done` out, 1: one-cycle pulse when `mux_sel` commits a new value.
- `switch_forced` out, 1: one-cycle pulse, coincident with `switch_done`, when the commit was caused by a timeout.
- `switch_abort` out, 1: one-cycle pulse when a sequence ends without a commit.
- `switch_count` out, CNT_W: saturating count of commits.

## Operation

States: IDLE, DRAIN, GAP, DWELL. `cur` is the value currently on `mux_sel`; `tgt` is the latched target.

IDLE:
- Enter DRAIN when `sel_req != cur` and `sync[sel_req]` is 1. Latch `tgt = sel_req` and clear the timeout counter.
- If `sync[sel_req]` is 0, the request is ignored. No mute, no pulse.

DRAIN (waiting for the current packet to end):
- `pkt_start[cur]` → GAP, with `mute` = 1.
- `sel_req == cur` → IDLE, pulse `switch_abort`.
- `sel_req` is a different third channel with sync → retarget `tgt`. The timeout counter is not cleared.
- `sync[tgt]` drops → IDLE, pulse `switch_abort`.
- Timeout reaches `TIMEOUT` (old channel has no boundaries) → GAP.
- Priority order: sync loss, cancel, `pkt_start`, retarget, timeout.

GAP (output muted, waiting for the target packet start):
- `pkt_start[tgt]` → `mux_sel = tgt`, `mute` = 0, pulse `switch_done`, increment `switch_count`, go to DWELL.
- `sync[tgt]` drops → `mute` = 0, `mux_sel` unchanged, pulse `switch_abort`, go to IDLE. Partial-packet emission is accepted here.
- Timeout → commit as for `pkt_start[tgt]`, and also pulse `switch_forced`.
- Changes on `sel_req` are ignored in GAP.

DWELL:
- Load the dwell counter with `hold_cycles` and decrement it once per cycle.
- At zero → IDLE. `hold_cycles = 0` gives a single DWELL cycle.
- All requests are ignored in DWELL.

Arithmetic and saturation:
- The timeout counter is `TMO_W` bits and saturates at `TIMEOUT`.
- `switch_count` saturates at all-ones; it never wraps.

## Timing

Reset values (state IDLE):
- `mux_sel` = 2'b00
- `mute` = 0
- `busy` = 0
- all pulses = 0
- `switch_count` = 0
- dwell counter = 0, so the first switch needs no dwell.

Register behaviour:
- All outputs are registered.
- A strobe sampled in cycle N takes effect on outputs in cycle N+1.
- `sel_req` change in cycle N → `busy` = 1 in cycle N+1.
- `pkt_start[cur]` in DRAIN at cycle N → `mute` = 1 from cycle N+1.
- `pkt_start[tgt]` in GAP at cycle M → `mux_sel = tgt`, `mute` = 0, and `switch_done` = 1, all in cycle M+1.
- The datapath's one-stage input register makes this edge packet-aligned.

Boundary cases:
- `pkt_start[cur]` and `pkt_start[tgt]` both in the DRAIN entry cycle: only strobes seen in DRAIN count, so the earliest possible transition is the cycle after entry.
- `pkt_start[cur]` and `pkt_start[tgt]` in the same DRAIN cycle: go to GAP, then wait for the next `pkt_start[tgt]`.
- `rst` mid-sequence: next cycle is IDLE with reset values. `mute` drops immediately and `switch_count` is cleared.

## Structure

Shared package `ts_qos_pkg`:
- state encoding `sw_state_t`.
- `CH_W = 2`.
- `NUM_CH = 4`.
- `TS_SYNC_BYTE = 8'h47`.

Module layout:
- Flat FSM plus counters.
- No sub-module is needed, other than an optional reusable `sat_counter` for `switch_count` and the timeout counter.

## Test plan

1. **Reset:** assert `rst` for 2 cycles with `sel_req = 3`, `sync = 4'hF`. Required: `mux_sel = 0`, `mute = 0`, `busy = 0` during reset, then `busy = 1` the cycle after release.
2. **Clean switch:** `sel_req = 2`, `sync = 4'b0101`, `pkt_start[0]` at cycle 10, `pkt_start[2]` at cycle 30. Required: `mute` = 1 over cycles 11–30, `mux_sel = 2` and `switch_done` at cycle 31, `switch_count = 1`.
3. **Dwell:** `hold_cycles = 50`, then `sel_req` returns to 0 right after the test 2 commit. Required: `busy` stays high and no DRAIN entry until the dwell expires; the second switch then completes with `switch_count = 2`.
4. **Unsynced or cancelled request:** `sel_req = 3` with `sync[3] = 0`. Required: no state change and no `mute`. Separately, a request that reverts to `cur` in DRAIN gives a `switch_abort` pulse, no `mute`, and an unchanged count.
5. **GAP timeout:** no `pkt_start[tgt]` for `TIMEOUT` cycles. Required: a forced commit with `switch_done` and `switch_forced` pulsing together.
6. **Sync loss in GAP:** `sync[tgt]` drops in GAP. Required: `switch_abort` pulse, `mute` = 0, and `mux_sel` unchanged.
